// File: rtl/cam_match_iterator.sv
// Serializes a CAM match vector into a stream of matching entry addresses,
// lowest first, and reports the vector's popcount and an all-zero pulse.
module cam_match_iterator #(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRIES-1:0] match_vec,
  input  logic               match_valid,
  output logic               match_ready,
  output logic [ADDR_W-1:0]  addr,
  output logic               valid,
  input  logic               out_ready,
  output logic               last,
  output logic [CNT_W-1:0]   num_match,
  output logic               no_match
);

  typedef enum logic {IDLE, ITER} state_t;

  state_t             state_q, state_d;
  logic [ENTRIES-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]   num_match_q, num_match_d;
  logic               no_match_q, no_match_d;
  logic [ADDR_W-1:0]  addr_enc;
  logic               one_hot;

  // Pairwise adder tree, reduced in place: level widths ENTRIES/2, /4, ... 1.
  function automatic logic [CNT_W-1:0] popcount(input logic [ENTRIES-1:0] v);
    logic [CNT_W-1:0] s [ENTRIES];
    for (int i = 0; i < ENTRIES; i++) s[i] = CNT_W'(v[i]);
    for (int w = ENTRIES / 2; w >= 1; w = w / 2)
      for (int j = 0; j < w; j++) s[j] = s[2*j] + s[2*j+1];
    return s[0];
  endfunction

  always_comb begin
    addr_enc = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (pend_q[i]) addr_enc = ADDR_W'(i);
  end

  assign one_hot = (pend_q != '0) && ((pend_q & (pend_q - ENTRIES'(1))) == '0);

  assign match_ready = (state_q == IDLE);
  assign valid       = (state_q == ITER);
  assign addr        = addr_enc;
  assign last        = one_hot;
  assign num_match   = num_match_q;
  assign no_match    = no_match_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    num_match_d = num_match_q;
    no_match_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (match_valid) begin
          pend_d      = match_vec;
          num_match_d = popcount(match_vec);
          if (match_vec == '0) no_match_d = 1'b1;
          else                 state_d    = ITER;
        end
      end
      ITER: begin
        // match_valid is deliberately ignored here; a new vector is dropped.
        if (out_ready) begin
          pend_d = pend_q & (pend_q - ENTRIES'(1));
          if (one_hot) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      num_match_q <= '0;
      no_match_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      num_match_q <= num_match_d;
      no_match_q  <= no_match_d;
    end
  end

endmodule

// File: tb/tb_cam_match_iterator.sv
// Scoreboard bench for cam_match_iterator: expected addresses are queued at
// capture time and compared as the DUT presents / transfers them.
module tb_cam_match_iterator;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] match_vec;
  logic       match_valid;
  logic       match_ready;
  logic [2:0] addr;
  logic       valid;
  logic       out_ready;
  logic       last;
  logic [3:0] num_match;
  logic       no_match;

  int n_chk = 0;
  int n_err = 0;
  int xfers = 0;

  typedef struct {
    logic [2:0] a;
    logic       l;
  } exp_t;
  exp_t sbq[$];

  cam_match_iterator dut (
    .clk(clk), .reset(reset), .match_vec(match_vec), .match_valid(match_valid),
    .match_ready(match_ready), .addr(addr), .valid(valid), .out_ready(out_ready),
    .last(last), .num_match(num_match), .no_match(no_match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [7:0] v);
    logic [7:0] sh;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        exp_t e;
        sh  = v >> (i + 1);
        e.a = 3'(i);
        e.l = (sh == 8'h00);
        sbq.push_back(e);
      end
    end
  endtask

  // Present a vector for one capture edge; expectations are queued now.
  task automatic capture(input logic [7:0] v);
    match_vec   = v;
    match_valid = 1'b1;
    push_vec(v);
    cyc();
    match_valid = 1'b0;
    match_vec   = $urandom;
  endtask

  task automatic drain(input int max, output int n);
    n = 0;
    while (valid && n < max) begin
      cyc();
      n++;
    end
    if (n >= max) chk("timeout", 1, 0);
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("nm_with_valid", 32'(no_match && valid), 0);
      if (valid) begin
        if (sbq.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          chk("addr", 32'(addr), 32'(sbq[0].a));
          chk("last", 32'(last), 32'(sbq[0].l));
          if (out_ready) begin
            void'(sbq.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] pat;
    reset = 1'b1; match_vec = '0; match_valid = 1'b0; out_ready = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      match_vec = $urandom; match_valid = 1'($urandom); out_ready = 1'($urandom);
      cyc();
    end
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ready", 32'(match_ready), 1);
    chk("rst_num", 32'(num_match), 0);
    chk("rst_nomatch", 32'(no_match), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_last", 32'(last), 0);
    match_valid = 1'b0; out_ready = 1'b1;
    reset = 1'b0;
    cyc();

    // Three hits, full throughput.
    capture(8'b1010_0100);
    chk("t1_num", 32'(num_match), 3);
    chk("t1_valid_lat", 32'(valid), 1);
    chk("t1_ready_busy", 32'(match_ready), 0);
    drain(20, n);
    chk("t1_cycles", n, 3);
    chk("t1_ready_after", 32'(match_ready), 1);
    chk("t1_sb_empty", sbq.size(), 0);

    // All-zero vector.
    capture(8'h00);
    chk("t2_nomatch", 32'(no_match), 1);
    chk("t2_num", 32'(num_match), 0);
    chk("t2_valid", 32'(valid), 0);
    chk("t2_ready", 32'(match_ready), 1);
    cyc();
    chk("t2_nomatch_pulse", 32'(no_match), 0);
    chk("t2_valid2", 32'(valid), 0);

    // All ones with stalls.
    xfers = 0;
    pat = 4'b1001;
    capture(8'hFF);
    chk("t3_num", 32'(num_match), 8);
    n = 0;
    while (valid && n < 100) begin
      out_ready = pat[n % 4];
      cyc();
      n++;
    end
    if (n >= 100) chk("t3_timeout", 1, 0);
    chk("t3_xfers", xfers, 8);
    chk("t3_sb_empty", sbq.size(), 0);
    chk("t3_num_hold", 32'(num_match), 8);
    out_ready = 1'b1;
    cyc();

    // Second vector offered during ITER must be dropped.
    capture(8'b1000_0001);
    match_vec = 8'h0F; match_valid = 1'b1;
    cyc();
    match_valid = 1'b0;
    drain(20, n);
    cyc();
    chk("t4_num", 32'(num_match), 2);
    chk("t4_valid", 32'(valid), 0);
    chk("t4_sb_empty", sbq.size(), 0);

    // Reset in the middle of an iteration.
    capture(8'b0111_0000);
    cyc();
    out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sbq.delete();
    chk("t5_valid", 32'(valid), 0);
    chk("t5_ready", 32'(match_ready), 1);
    chk("t5_num", 32'(num_match), 0);
    out_ready = 1'b1;
    capture(8'b0000_0010);
    chk("t5_num2", 32'(num_match), 1);
    drain(20, n);
    chk("t5_cycles", n, 1);
    chk("t5_sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
